// File: rtl/freq_meter.sv
// freq_meter: measures an incoming square wave in clk cycles.
// Reports the last half-period, the last full period (high half plus the
// following low half), a lock flag for consecutive periods within TOL, and a
// timeout flag when no edge arrives for TIMEOUT_CYC cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | measurement disabled, counter held at zero
// WAIT_FIRST | enabled, waiting for the reference edge (no pulse on it)
// MEASURE    | every edge produces a half-period, rises may close a period
// STALE      | input stopped toggling; next edge re-arms without a pulse
module freq_meter #(
  parameter int CLK_FRQ     = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = CLK_FRQ / 10,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             half_valid,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    STALE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);

  state_t           state;
  logic             sync1, sync2, sync3;
  logic             sig_edge, rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_reg;
  logic             have_high;
  logic             have_prev;
  logic [CNT_W:0]   prev_period;
  logic [CNT_W:0]   period_new;
  logic [CNT_W:0]   period_diff;
  logic             within_tol;

  // Two-flop synchronizer plus a history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign sig_edge = sync2 ^ sync3;
  assign rise     = sig_edge & sync2;
  assign fall     = sig_edge & ~sync2;

  // The counter is cleared on the edge cycle, so the interval is cnt + 1
  assign cnt_inc     = cnt + CNT_W'(1);
  assign period_new  = {1'b0, high_reg} + {1'b0, cnt_inc};
  assign period_diff = (period_new >= prev_period) ? (period_new - prev_period)
                                                   : (prev_period - period_new);
  assign within_tol  = (period_diff <= TOL_W);

  // Measurement FSM with registered results, flags and one-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      high_reg     <= '0;
      have_high    <= 1'b0;
      have_prev    <= 1'b0;
      prev_period  <= '0;
      half_period  <= '0;
      half_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      half_valid   <= 1'b0;
      period_valid <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        have_high <= 1'b0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT_FIRST;
          end
          WAIT_FIRST, MEASURE: begin
            if (sig_edge) begin
              cnt   <= '0;
              state <= MEASURE;
              if (state == MEASURE) begin
                half_period <= cnt_inc;
                half_valid  <= 1'b1;
                if (fall) begin
                  high_reg  <= cnt_inc;
                  have_high <= 1'b1;
                end
                if (rise && have_high) begin
                  period       <= period_new;
                  period_valid <= 1'b1;
                  prev_period  <= period_new;
                  have_prev    <= 1'b1;
                  if (!within_tol) begin
                    locked <= 1'b0;
                  end else if (have_prev) begin
                    locked <= 1'b1;
                  end
                end
              end
            end else if (cnt == CNT_LAST) begin
              // edge has priority; only a quiet terminal-count cycle times out
              state     <= STALE;
              timeout   <= 1'b1;
              locked    <= 1'b0;
              have_high <= 1'b0;
              have_prev <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          STALE: begin
            // cnt stays saturated at CNT_LAST until the input moves again
            if (sig_edge) begin
              cnt     <= '0;
              timeout <= 1'b0;
              state   <= MEASURE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed bench for freq_meter. Instance a is a small fast
// meter (16-bit, 100-cycle timeout) for the bulk of the cases; instance b uses
// full width to run the 25000-cycle divider loopback.
module tb_freq_meter;

  typedef logic [32:0] w_t;

  logic        clk;
  logic        rst;
  logic        en_a, sig_a, en_b, sig_b;
  logic [15:0] hp_a;
  logic [16:0] p_a;
  logic        hv_a, pv_a, lk_a, to_a;
  logic [31:0] hp_b;
  logic [32:0] p_b;
  logic        hv_b, pv_b, lk_b, to_b;

  int checks   = 0;
  int failures = 0;
  int consec   = 0;
  logic hv_a_d = 1'b0;
  logic pv_a_d = 1'b0;

  w_t hq_a[$], pq_a[$], lq_a[$];
  w_t hq_b[$], pq_b[$], lq_b[$];

  freq_meter #(.CNT_W(16), .TIMEOUT_CYC(100), .TOL(2)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_a),
    .half_period(hp_a), .half_valid(hv_a), .period(p_a), .period_valid(pv_a),
    .locked(lk_a), .timeout(to_a)
  );

  freq_meter #(.CNT_W(32), .TIMEOUT_CYC(60000), .TOL(2)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_b),
    .half_period(hp_b), .half_valid(hv_b), .period(p_b), .period_valid(pv_b),
    .locked(lk_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every pulse on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (hv_a) hq_a.push_back(w_t'(hp_a));
    if (pv_a) begin
      pq_a.push_back(w_t'(p_a));
      lq_a.push_back(w_t'(lk_a));
    end
    if ((hv_a && hv_a_d) || (pv_a && pv_a_d)) consec++;
    hv_a_d = hv_a;
    pv_a_d = pv_a;
    if (hv_b) hq_b.push_back(w_t'(hp_b));
    if (pv_b) begin
      pq_b.push_back(w_t'(p_b));
      lq_b.push_back(w_t'(lk_b));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_queue(input string tag, input w_t got[$], input w_t exp[$]);
    chk({tag, "_count"}, w_t'(got.size()), w_t'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic clear_a();
    hq_a.delete();
    pq_a.delete();
    lq_a.delete();
  endtask

  initial begin
    w_t exp_h[$], exp_p[$], exp_l[$];
    int n0, pn0;
    rst = 1'b0; en_a = 1'b0; sig_a = 1'b0; en_b = 1'b0; sig_b = 1'b0;
    tick(3);
    chk("rst_hp_a", w_t'(hp_a), 0);
    chk("rst_p_a", w_t'(p_a), 0);
    chk("rst_flags_a", w_t'({hv_a, pv_a, lk_a, to_a}), 0);
    chk("rst_hp_b", w_t'(hp_b), 0);
    chk("rst_p_b", w_t'(p_b), 0);
    chk("rst_flags_b", w_t'({hv_b, pv_b, lk_b, to_b}), 0);
    rst = 1'b1;
    tick(2);

    // divider loopback, 25000-cycle half-periods
    en_b = 1'b1;
    tick(3);
    sig_b = 1'b1;
    tick(25000);
    chk("loop_first_edge_no_half", w_t'(hq_b.size()), 0);
    chk("loop_first_edge_no_period", w_t'(pq_b.size()), 0);
    sig_b = 1'b0;
    tick(25000);
    sig_b = 1'b1;
    tick(5);
    check_queue("loop_half", hq_b, '{25000, 25000});
    check_queue("loop_period", pq_b, '{50000});
    check_queue("loop_lock", lq_b, '{0});
    chk("loop_p_out", p_b, 50000);
    en_b = 1'b0;

    // asymmetric wave, high 10 / low 30
    en_a = 1'b1;
    tick(3);
    clear_a();
    for (int i = 0; i < 4; i++) begin
      sig_a = 1'b1; tick(10);
      sig_a = 1'b0; tick(30);
    end
    sig_a = 1'b1;
    tick(20);
    check_queue("asym_half", hq_a, '{10, 30, 10, 30, 10, 30, 10, 30});
    check_queue("asym_period", pq_a, '{40, 40, 40, 40});
    check_queue("asym_lock", lq_a, '{0, 1, 1, 1});

    en_a = 1'b0;
    tick(2);
    chk("endrop_lock_clear", w_t'(lk_a), 0);
    chk("endrop_hp_held", w_t'(hp_a), 30);
    chk("endrop_p_held", w_t'(p_a), 40);

    // jitter: periods 40, 41, 45, 45
    en_a = 1'b1;
    tick(3);
    clear_a();
    sig_a = 1'b0; tick(20);
    sig_a = 1'b1; tick(20);
    foreach (exp_h[i]) exp_h.delete(i);
    exp_h = '{20, 20, 20, 20, 21, 20, 25, 20, 25};
    exp_p = '{40, 41, 45, 45};
    exp_l = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      sig_a = 1'b0; tick(int'(exp_p[i]) - 20);
      sig_a = 1'b1; tick(20);
    end
    check_queue("jit_half", hq_a, exp_h);
    check_queue("jit_period", pq_a, exp_p);
    check_queue("jit_lock", lq_a, exp_l);

    // timeout: last edge registered 3 cycles after the change, so the flag
    // rises 103 cycles after that change
    tick(82);
    chk("tmo_before_flag", w_t'(to_a), 0);
    chk("tmo_before_lock", w_t'(lk_a), 1);
    tick(1);
    chk("tmo_flag", w_t'(to_a), 1);
    chk("tmo_lock_clear", w_t'(lk_a), 0);
    tick(50);
    chk("tmo_flag_stays", w_t'(to_a), 1);
    n0  = hq_a.size();
    pn0 = pq_a.size();
    sig_a = 1'b0; tick(10);
    chk("resume_flag_clear", w_t'(to_a), 0);
    chk("resume_no_pulse", w_t'(hq_a.size()), w_t'(n0));
    sig_a = 1'b1; tick(10);
    chk("resume_half_count", w_t'(hq_a.size()), w_t'(n0 + 1));
    chk("resume_half_val", w_t'(hp_a), 10);
    chk("resume_no_period", w_t'(pq_a.size()), w_t'(pn0));

    // en drop mid-half-period after relocking at period 20
    clear_a();
    for (int i = 0; i < 3; i++) begin
      sig_a = 1'b0; tick(10);
      sig_a = 1'b1; tick(10);
    end
    check_queue("relock_period", pq_a, '{20, 20, 20});
    check_queue("relock_lock", lq_a, '{0, 1, 1});
    sig_a = 1'b0;
    tick(5);
    clear_a();
    en_a = 1'b0;
    tick(1);
    chk("mid_en_lock", w_t'(lk_a), 0);
    chk("mid_en_tmo", w_t'(to_a), 0);
    tick(5);
    chk("mid_en_no_pulse", w_t'(hq_a.size() + pq_a.size()), 0);
    chk("mid_en_hp_held", w_t'(hp_a), 10);
    chk("mid_en_p_held", w_t'(p_a), 20);

    // minimum rate: toggle every 2 cycles
    en_a = 1'b1;
    tick(3);
    clear_a();
    consec = 0;
    for (int i = 0; i < 8; i++) begin
      sig_a = ~sig_a;
      tick(2);
    end
    tick(3);
    check_queue("min_half", hq_a, '{2, 2, 2, 2, 2, 2, 2});
    check_queue("min_period", pq_a, '{4, 4, 4});
    check_queue("min_lock", lq_a, '{0, 1, 1});
    chk("min_no_back_to_back", w_t'(consec), 0);

    // asynchronous reset mid-measurement
    for (int i = 0; i < 3; i++) begin
      sig_a = ~sig_a;
      tick(2);
    end
    rst = 1'b0;
    #1;
    chk("arst_hp", w_t'(hp_a), 0);
    chk("arst_p", w_t'(p_a), 0);
    chk("arst_flags", w_t'({hv_a, pv_a, lk_a, to_a}), 0);
    chk("arst_hp_b", w_t'(hp_b), 0);
    tick(2);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
